// File: rtl/uart_apb_master_if.sv
// Bundle of the command channel, response channel, APB3 bus and status
// signals of uart_apb_master.
//   master modport : the requester's view (commands/APB responses in,
//                    responses/APB requests/status out)
//   slave  modport : the environment's view (reverse directions)
// Signal names keep their i_/o_ prefixes as seen from the requester.
interface uart_apb_master_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
);
  // command channel
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic                      i_cmd_write;
  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr;
  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata;
  // response channel
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [APB_DATA_WIDTH-1:0] o_rsp_rdata;
  logic                      o_rsp_err;
  logic                      o_rsp_timeout;
  // APB3 bus
  logic [APB_ADDR_WIDTH-1:0] o_apb_paddr;
  logic [APB_DATA_WIDTH-1:0] o_apb_pwdata;
  logic                      o_apb_pwrite;
  logic                      o_apb_psel;
  logic                      o_apb_penable;
  logic [APB_DATA_WIDTH-1:0] i_apb_prdata;
  logic                      i_apb_pready;
  logic                      i_apb_pslverr;
  // status
  logic [ERR_CNT_WIDTH-1:0]  o_err_cnt;
  logic                      o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
           i_apb_prdata, i_apb_pready, i_apb_pslverr,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable,
           o_err_cnt, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
           i_apb_prdata, i_apb_pready, i_apb_pslverr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_apb_paddr, o_apb_pwdata, o_apb_pwrite, o_apb_psel, o_apb_penable,
           o_err_cnt, o_busy
  );
endinterface

// File: rtl/uart_apb_master.sv
// APB3 requester for the UART register map. Takes one read/write command
// per valid/ready handshake, runs a single SETUP/ACCESS transfer and hands
// back read data / error status on a valid/ready response channel.
// Ports:
//   i_clk  : clock, all logic on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : uart_apb_master_if.master (command, response, APB3, status)
// Optional build macro:
//   UART_APB_MASTER_TIMEOUT_EN : abort an ACCESS phase after TIMEOUT_CYCLES
//   wait cycles (response err=1, timeout=1, rdata=0). Undefined: ACCESS
//   waits indefinitely and o_rsp_timeout is tied to 0.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  uart_apb_master_if.master  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Abort fires on the cycle whose wait would make the count reach the limit.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state, state_nxt;

  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;

  logic cmd_ready, cmd_hs, rsp_hs, acc_done, acc_abort;

  // Not ready while reset is asserted, even though state already reads IDLE.
  assign cmd_ready = (state == IDLE) && !i_rst;
  assign cmd_hs    = bus.i_cmd_valid && cmd_ready;
  assign rsp_hs    = (state == RESP) && bus.i_rsp_ready;
  assign acc_done  = (state == ACCESS) && bus.i_apb_pready;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        tmo_q;

  // pready in the expiry cycle wins over the abort.
  assign acc_abort = (state == ACCESS) && !bus.i_apb_pready && (tcnt_q == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (state == SETUP)
        tcnt_q <= '0;
      else if (state == ACCESS && !bus.i_apb_pready)
        tcnt_q <= tcnt_q + 16'd1;
      if (acc_done)
        tmo_q <= 1'b0;
      else if (acc_abort)
        tmo_q <= 1'b1;
    end
  end

  assign bus.o_rsp_timeout = tmo_q;
`else
  wire unused_tmo = ^TMO_LAST;
  assign acc_abort         = 1'b0;
  assign bus.o_rsp_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (acc_done || acc_abort) state_nxt = RESP;
      RESP:    if (bus.i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (cmd_hs) begin
        paddr_q  <= bus.i_cmd_addr;
        pwdata_q <= bus.i_cmd_wdata;
        pwrite_q <= bus.i_cmd_write;
      end
      if (acc_done) begin
        rdata_q <= pwrite_q ? '0 : bus.i_apb_prdata;
        err_q   <= bus.i_apb_pslverr;
      end else if (acc_abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      // Saturate at all-ones; never wraps.
      if (rsp_hs && err_q && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_rsp_valid   = (state == RESP);
  assign bus.o_rsp_rdata   = rdata_q;
  assign bus.o_rsp_err     = err_q;
  assign bus.o_apb_paddr   = paddr_q;
  assign bus.o_apb_pwdata  = pwdata_q;
  assign bus.o_apb_pwrite  = pwrite_q;
  assign bus.o_apb_psel    = (state == SETUP) || (state == ACCESS);
  assign bus.o_apb_penable = (state == ACCESS);
  assign bus.o_err_cnt     = err_cnt_q;
  assign bus.o_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_apb_master.sv
module tb_uart_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  uart_apb_master_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus ();

  uart_apb_master #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(CW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   prdata;
    int            ws;
    logic          slverr;
    int            hold;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t sbq[$];
  vec_t vecs[7];
  int   checks = 0;
  int   passed = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pops the oldest expected response and compares the presented one, then
  // completes the handshake and checks the status afterwards.
  task automatic consume();
    rsp_t e;
    if (sbq.size() == 0) begin
      checks++;
      $display("FAIL sb_empty: got response with no expectation queued");
      e = '{32'h0, 1'b0, 1'b0};
    end else begin
      e = sbq.pop_front();
    end
    chk("rsp_valid", bus.o_rsp_valid, 1);
    chk("rsp_rdata", bus.o_rsp_rdata, e.rdata);
    chk("rsp_err", bus.o_rsp_err, e.err);
    chk("rsp_timeout", bus.o_rsp_timeout, e.tmo);
    bus.i_rsp_ready = 1'b1;
    @(negedge i_clk);
    bus.i_rsp_ready = 1'b0;
    bus.i_cmd_valid = 1'b0;
    if (e.err && exp_cnt < CNT_MAX) exp_cnt++;
    chk("err_cnt", bus.o_err_cnt, exp_cnt);
    chk("idle_busy", bus.o_busy, 0);
    chk("idle_cmd_ready", bus.o_cmd_ready, 1);
    chk("idle_rsp_valid", bus.o_rsp_valid, 0);
  endtask

  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_write = wr;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_wdata = wdata;
    chk("cmd_ready", bus.o_cmd_ready, 1);
    @(negedge i_clk);
    bus.i_cmd_valid = 1'b0;
    // SETUP cycle
    chk("setup_psel", bus.o_apb_psel, 1);
    chk("setup_penable", bus.o_apb_penable, 0);
    chk("setup_paddr", bus.o_apb_paddr, addr);
    chk("setup_pwrite", bus.o_apb_pwrite, wr);
    @(negedge i_clk);
  endtask

  task automatic run_vec(input vec_t v);
    sbq.push_back('{v.exp_rdata, v.exp_err, 1'b0});
    start_cmd(v.wr, v.addr, v.wdata);
    for (int w = 0; w <= v.ws; w++) begin
      // Wait cycles present inverted data/error that must be ignored.
      bus.i_apb_pready  = (w == v.ws);
      bus.i_apb_prdata  = (w == v.ws) ? v.prdata : ~v.prdata;
      bus.i_apb_pslverr = (w == v.ws) ? v.slverr : ~v.slverr;
      chk("acc_psel", bus.o_apb_psel, 1);
      chk("acc_penable", bus.o_apb_penable, 1);
      chk("acc_paddr", bus.o_apb_paddr, v.addr);
      if (v.wr) chk("acc_pwdata", bus.o_apb_pwdata, v.wdata);
      @(negedge i_clk);
    end
    bus.i_apb_pready  = 1'b0;
    bus.i_apb_pslverr = 1'b0;
    bus.i_apb_prdata  = 32'h0;
    chk("resp_latency", bus.o_rsp_valid, 1);
    chk("resp_psel", bus.o_apb_psel, 0);
    chk("resp_penable", bus.o_apb_penable, 0);
    if (v.hold > 0) begin
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_write = 1'b0;
      bus.i_cmd_addr  = 32'h0000_FFF0;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge i_clk);
        chk("hold_rsp_valid", bus.o_rsp_valid, 1);
        chk("hold_rdata", bus.o_rsp_rdata, v.exp_rdata);
        chk("hold_cmd_ready", bus.o_cmd_ready, 0);
        chk("hold_psel", bus.o_apb_psel, 0);
      end
    end
    for (int k = 0; k < 20 && !bus.o_rsp_valid; k++) @(negedge i_clk);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    //       wr    addr          wdata         prdata        ws slv hold exp_rdata     err
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 0, 1'b0, 0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 3, 1'b0, 0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0055, 0, 1'b1, 0, 32'h0000_0055, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_000C, 32'h0F0F_0F0F, 32'h7777_7777, 1, 1'b1, 0, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 5, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0018, 32'h0,         32'h8000_0001, 2, 1'b1, 0, 32'h8000_0001, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_001C, 32'h1111_2222, 32'h0,         0, 1'b1, 0, 32'h0,         1'b1};

    i_rst = 1'b1;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0;
    bus.i_cmd_addr = '0; bus.i_cmd_wdata = '0; bus.i_rsp_ready = 1'b0;
    bus.i_apb_prdata = '0; bus.i_apb_pready = 1'b0; bus.i_apb_pslverr = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_cmd_ready", bus.o_cmd_ready, 0);
    chk("rst_psel", bus.o_apb_psel, 0);
    chk("rst_penable", bus.o_apb_penable, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_err_cnt", bus.o_err_cnt, 0);
    chk("rst_paddr", bus.o_apb_paddr, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of an ACCESS phase.
    start_cmd(1'b0, 32'h0000_0020, 32'h0);
    chk("mid_penable", bus.o_apb_penable, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    exp_cnt = 0;
    chk("mid_rst_psel", bus.o_apb_psel, 0);
    chk("mid_rst_penable", bus.o_apb_penable, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("mid_rst_err_cnt", bus.o_err_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_rsp_after", bus.o_rsp_valid, 0);
    run_vec('{1'b0, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 0, 32'h0BAD_F00D, 1'b0});

`ifdef UART_APB_MASTER_TIMEOUT_EN
    // pready never comes: abort after TO wait cycles.
    sbq.push_back('{32'h0, 1'b1, 1'b1});
    start_cmd(1'b0, 32'h0000_0030, 32'h0);
    bus.i_apb_prdata = 32'h7777_7777;
    for (int w = 0; w < TO; w++) begin
      chk("tmo_penable", bus.o_apb_penable, 1);
      @(negedge i_clk);
    end
    bus.i_apb_prdata = 32'h0;
    chk("tmo_psel_drop", bus.o_apb_psel, 0);
    consume();
    // pready on the last allowed wait cycle completes normally.
    run_vec('{1'b0, 32'h0000_0034, 32'h0, 32'h600D_600D, TO - 1, 1'b0, 0, 32'h600D_600D, 1'b0});
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
